acq_run_sequencer: RTL

- Sequences an acquisition run for the free-running tick counter datapath.
- Takes level-style PS control-register bits and converts them to edge commands.
- Generates a phase-aligned slow tick, applies a programmable start delay and a bounded or unbounded run length, and drives the counter's 32-bit enable word.
- Reports state, elapsed ticks and a sticky done/abort status back to a PS-readable register.

---
 rtl/acq_run_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/acq_run_sequencer.sv
// acq_run_sequencer: sequences one acquisition run for the tick counter datapath.
// Converts level PS control bits to edge commands, divides clk down to a slow
// tick, applies a start delay and a bounded/unbounded run length, and reports
// state, elapsed ticks and sticky done/abort status.
//
// Ports:
//   clk         in   fabric clock
//   rst         in   synchronous active-high reset
//   ctrl        in   [0] start, [1] stop, [2] clear_status (edge-triggered)
//                    [3] continuous mode (only with CONTINUOUS_RUN_EN)
//   duration    in   run length in ticks, 0 = unbounded
//   start_delay in   ticks between start and run enable
//   run_enable  out  32'h1 while running
//   tick        out  one-cycle pulse every DIV cycles in DELAY/RUN
//   elapsed     out  ticks counted in RUN (saturating)
//   run_done    out  one-cycle pulse on run completion
//   status      out  [1:0] state, [2] done, [3] aborted, [4] busy
//
// Optional feature macro: CONTINUOUS_RUN_EN (continuous re-arming runs).
module acq_run_sequencer #(
    parameter int unsigned CLK_HZ  = 84000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned DELAY_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ctrl,
    input  logic [31:0]        duration,
    input  logic [DELAY_W-1:0] start_delay,
    output logic [31:0]        run_enable,
    output logic               tick,
    output logic [31:0]        elapsed,
    output logic               run_done,
    output logic [31:0]        status
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("acq_run_sequencer: CLK_HZ/TICK_HZ must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nx;
    logic [2:0]         r_ctrl_q;
    logic [DW-1:0]      r_div, w_div_nx;
    logic [31:0]        r_dur, w_dur_nx;
    logic [DELAY_W-1:0] r_dly, w_dly_nx;
    logic [31:0]        r_elapsed, w_elapsed_nx;
    logic               r_done_stk, r_abort_stk;
    logic               r_run_done, w_run_done_nx;
    logic               r_cont, w_cont_nx;
    logic               w_set_done, w_set_abort;
    logic               w_start_p, w_stop_p, w_clr_p;
    logic               w_busy, w_tick, w_last, w_cont_sel;
    logic [31:0]        w_inc;
    logic               w_unused;

`ifdef CONTINUOUS_RUN_EN
    assign w_cont_sel = ctrl[3];
    assign w_unused   = ^ctrl[31:4];
`else
    assign w_cont_sel = 1'b0;
    assign w_unused   = ^ctrl[31:3];
`endif

    assign w_start_p = ctrl[0] & ~r_ctrl_q[0];
    assign w_stop_p  = ctrl[1] & ~r_ctrl_q[1];
    assign w_clr_p   = ctrl[2] & ~r_ctrl_q[2];

    assign w_busy = (r_state == S_DELAY) || (r_state == S_RUN);
    assign w_tick = w_busy && (r_div == DIV_M1);

    // Saturating increment; completion compares against the incremented value
    assign w_inc  = (&r_elapsed) ? r_elapsed : r_elapsed + 32'd1;
    assign w_last = (r_dur != 32'd0) && (w_inc == r_dur);

    always_comb begin
        w_state_nx    = r_state;
        w_div_nx      = r_div;
        w_dur_nx      = r_dur;
        w_dly_nx      = r_dly;
        w_elapsed_nx  = r_elapsed;
        w_cont_nx     = r_cont;
        w_run_done_nx = 1'b0;
        w_set_done    = 1'b0;
        w_set_abort   = 1'b0;
        if (w_busy) begin
            w_div_nx = w_tick ? '0 : r_div + DW'(1);
        end
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_p) begin
                    w_dur_nx     = duration;
                    w_dly_nx     = start_delay;
                    w_elapsed_nx = '0;
                    w_div_nx     = '0;
                    w_cont_nx    = w_cont_sel;
                    w_state_nx   = (start_delay != '0) ? S_DELAY : S_RUN;
                end else if (w_stop_p && (r_state == S_DONE)) begin
                    w_div_nx   = '0;
                    w_state_nx = S_IDLE;
                end
            end
            S_DELAY: begin
                if (w_stop_p) begin
                    w_state_nx  = S_IDLE;
                    w_set_abort = 1'b1;
                end else if (w_tick) begin
                    w_dly_nx = r_dly - DELAY_W'(1);
                    if (r_dly == DELAY_W'(1)) begin
                        w_state_nx = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_tick) begin
                    w_elapsed_nx = w_inc;
                    if (w_last) begin
                        w_run_done_nx = 1'b1;
                        w_set_done    = 1'b1;
                        if (r_cont) begin
                            w_elapsed_nx = '0;
                        end else begin
                            w_state_nx = S_DONE;
                        end
                    end
                end
                // A stop landing on the completing tick loses to completion
                if (w_stop_p && !(w_tick && w_last && !r_cont)) begin
                    w_state_nx  = S_DONE;
                    w_set_abort = !r_cont;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ctrl_q    <= '0;
            r_div       <= '0;
            r_dur       <= '0;
            r_dly       <= '0;
            r_elapsed   <= '0;
            r_done_stk  <= 1'b0;
            r_abort_stk <= 1'b0;
            r_run_done  <= 1'b0;
            r_cont      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ctrl_q   <= ctrl[2:0];
            r_div      <= w_div_nx;
            r_dur      <= w_dur_nx;
            r_dly      <= w_dly_nx;
            r_elapsed  <= w_elapsed_nx;
            r_run_done <= w_run_done_nx;
            r_cont     <= w_cont_nx;
            // Set events take priority over a coincident clear
            if (w_set_done) begin
                r_done_stk <= 1'b1;
            end else if (w_clr_p) begin
                r_done_stk <= 1'b0;
            end
            if (w_set_abort) begin
                r_abort_stk <= 1'b1;
            end else if (w_clr_p) begin
                r_abort_stk <= 1'b0;
            end
        end
    end

    assign run_enable = {31'b0, (r_state == S_RUN)};
    assign tick       = w_tick;
    assign elapsed    = r_elapsed;
    assign run_done   = r_run_done;
    assign status     = {27'b0, w_busy, r_abort_stk, r_done_stk, r_state};

endmodule
